data_path: RTL and testbench
============================

// Module: data_path
// PURPOSE
// - 32-bit single-bus CPU datapath, driven cycle by cycle by an external control unit or bench.
// - Contains R0-R15, PC, HI, LO, Y, Z(64b), MAR, MDR, C and InPort registers, plus a shared bus mux and an ALU.
// - Register-transfer steps are selected by one-hot *out/*in strobes; the ALU operation is selected by opcode.
// PARAMETERS
// - WIDTH  32  datapath/register width; Z is 2*WIDTH.
// PORTS
// clock       in   1    rising-edge clock for all state
// clear       in   1    reset, asynchronous, active-low
// R0in..R15in in   1ea  load GPR n from bus
// PCin        in   1    load PC from bus
// HIin/LOin   in   1ea  load HI/LO from bus
// Zin         in   1    load Z from ALU result
// incPC       in   1    ALU computes bus+1, overriding opcode
// MARin       in   1    load MAR from bus
// MDRin       in   1    load MDR (source chosen by read)
// read        in   1    MDR source: 1=Mdatain, 0=bus
// InPortIn    in   1    load InPort register from InPortData
// Cin/Yin     in   1ea  load C/Y from bus
// opcode      in   5    ALU operation select
// Mdatain     in   32   memory read data
// InPortData  in   32   external input-port data
// R0out..R15out in 1ea  drive GPR n onto bus
// HIout/LOout in   1ea  drive HI/LO onto bus
// ZHighOut/ZLowOut in 1ea drive Z[63:32]/Z[31:0] onto bus
// PCout/MDRout/InPortOut/Cout in 1ea  drive that register onto bus
// BusMuxOut   out  32   current bus value (observation)
// MARout_q    out  32   MAR contents (memory address)
// BEHAVIOUR
// - clear low (async): every register, including Z, MAR and MDR, clears to 0. BusMuxOut then reads 0.
// - Bus is combinational.
//   - Priority: R0..R15 > HI > LO > ZHigh > ZLow > PC > MDR > InPort > C.
//   - No out strobe asserted: bus = 0.
// - Register loads occur on the rising clock edge when the *in strobe is high.
//   - R0 is an ordinary register.
//   - Simultaneous in-strobes all load the same bus value.
// - MDR loads Mdatain when read=1, and the bus when read=0; it loads only while MDRin=1.
// - ALU inputs: A=Y, B=bus. Result is 64 bits, captured in Z on Zin, so latency is 1 clock.
//   - incPC=1: Z = {32'b0, bus+1}.
//   - 00000 ADD    A+B
//   - 00001 SUB    A-B
//   - 00010 AND
//   - 00011 MUL    signed 64b product; LO half = Z[31:0], HI half = Z[63:32]
//   - 00100 DIV    signed; Z[31:0] = quotient, Z[63:32] = remainder; B=0 gives Z=0
//   - 00101 OR
//   - 00110 SHR    A>>B[4:0]
//   - 00111 SHL    A<<B[4:0]
//   - 01000 SHRA   A>>>B[4:0]
//   - 01001 ROR    by B[4:0]
//   - 01010 ROL    by B[4:0]
//   - 01011 NEG    -B
//   - 01100 NOT    ~B
//   - 32-bit ops zero Z[63:32]; undefined opcodes give Z=0.
// - Arithmetic wraps modulo 2^32; no flags.
// - Z written and read in the same cycle: the bus sees the old Z value.
// STRUCTURE
// - Shared package: WIDTH, ALU opcode localparams.
// - Sub-modules:
//   - alu: combinational; inputs A, B, opcode, incPC; 64-bit output.
//   - reg32: async-clear, load-enabled register, instantiated per register.
// TESTING
// - Reset: clear low mid-run -> all regs 0 immediately; BusMuxOut=0.
// - Load: Mdatain=25, read+MDRin; then MDRout+R2in -> R2=25. Same path gives R6=5.
// - MUL: R2out+Yin; opcode=00011, R6out+Zin; ZLowOut+LOin; ZHighOut+HIin -> LO=125, HI=0.
// - Signed MUL: Y=-25, B=5 -> HI=FFFFFFFF, LO=FFFFFF83.
// - PC: PC=0; PCout+incPC+MARin+Zin -> MAR=0, Z=1; ZLowOut+PCin -> PC=1.
// - DIV:
//   - Y=25, B=5 -> LO=5, HI=0.
//   - Y=7, B=0 -> Z=0.
//   - Two out strobes at once -> lower-priority source ignored.

Source files
------------

// File: rtl/data_path_pkg.sv
// Shared width and ALU opcode encodings for the single-bus datapath.
package data_path_pkg;
  localparam int DP_WIDTH = 32;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_MUL  = 5'b00011;
  localparam logic [4:0] OP_DIV  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_SHR  = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: A=Y, B=bus, 64-bit result destined for Z.
module alu
  import data_path_pkg::*;
#(
  parameter int W = DP_WIDTH
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [4:0]     opcode,
  input  logic           inc_pc,
  output logic [2*W-1:0] result
);
  localparam int SW = $clog2(W);

  logic [SW-1:0]         sh;
  logic signed [2*W-1:0] prod;
  logic signed [W-1:0]   divisor, quo, rem;
  logic [W-1:0]          ror_v, rol_v;

  assign sh      = b[SW-1:0];
  assign prod    = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  // divisor forced to 1 on B=0 so the divider never sees zero; result is masked below
  assign divisor = $signed((b == '0) ? {{(W-1){1'b0}}, 1'b1} : b);
  assign quo     = $signed(a) / divisor;
  assign rem     = $signed(a) % divisor;
  assign ror_v   = W'({a, a} >> sh);
  assign rol_v   = W'(({a, a} << sh) >> W);

  always_comb begin
    result = '0;
    if (inc_pc) begin
      result[W-1:0] = b + W'(1);
    end else begin
      case (opcode)
        OP_ADD:  result[W-1:0] = a + b;
        OP_SUB:  result[W-1:0] = a - b;
        OP_AND:  result[W-1:0] = a & b;
        OP_MUL:  result        = prod;
        OP_DIV:  if (b != '0) result = {rem, quo};
        OP_OR:   result[W-1:0] = a | b;
        OP_SHR:  result[W-1:0] = a >> sh;
        OP_SHL:  result[W-1:0] = a << sh;
        OP_SHRA: result[W-1:0] = $signed(a) >>> sh;
        OP_ROR:  result[W-1:0] = ror_v;
        OP_ROL:  result[W-1:0] = rol_v;
        OP_NEG:  result[W-1:0] = -b;
        OP_NOT:  result[W-1:0] = ~b;
        default: result        = '0;
      endcase
    end
  end
endmodule

// File: rtl/data_path_reg32.sv
// Async-clear, load-enabled register used for every datapath register.
module reg32 #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)    q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/data_path.sv
// Single-bus CPU datapath: register file, special registers, bus mux and ALU.
module data_path
  import data_path_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic             R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic             PCin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             Zin,
  input  logic             incPC,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             read,
  input  logic             InPortIn,
  input  logic             Cin,
  input  logic             Yin,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [WIDTH-1:0] InPortData,
  input  logic             R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
  input  logic             R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             ZHighOut,
  input  logic             ZLowOut,
  input  logic             PCout,
  input  logic             MDRout,
  input  logic             InPortOut,
  input  logic             Cout,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] MARout_q
);
  logic [15:0]          r_in, r_out;
  logic [WIDTH-1:0]     r_q [16];
  logic [WIDTH-1:0]     pc_q, hi_q, lo_q, y_q, mar_q, mdr_q, mdr_d, c_q, inport_q;
  logic [2*WIDTH-1:0]   z_q, alu_result;
  logic [WIDTH-1:0]     bus;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  for (genvar g = 0; g < 16; g++) begin : g_gpr
    reg32 #(.W(WIDTH)) u_r (.clock(clock), .clear(clear), .load(r_in[g]), .d(bus), .q(r_q[g]));
  end

  assign mdr_d = read ? Mdatain : bus;

  reg32 #(.W(WIDTH)) u_pc  (.clock(clock), .clear(clear), .load(PCin),     .d(bus),        .q(pc_q));
  reg32 #(.W(WIDTH)) u_hi  (.clock(clock), .clear(clear), .load(HIin),     .d(bus),        .q(hi_q));
  reg32 #(.W(WIDTH)) u_lo  (.clock(clock), .clear(clear), .load(LOin),     .d(bus),        .q(lo_q));
  reg32 #(.W(WIDTH)) u_y   (.clock(clock), .clear(clear), .load(Yin),      .d(bus),        .q(y_q));
  reg32 #(.W(WIDTH)) u_mar (.clock(clock), .clear(clear), .load(MARin),    .d(bus),        .q(mar_q));
  reg32 #(.W(WIDTH)) u_mdr (.clock(clock), .clear(clear), .load(MDRin),    .d(mdr_d),      .q(mdr_q));
  reg32 #(.W(WIDTH)) u_c   (.clock(clock), .clear(clear), .load(Cin),      .d(bus),        .q(c_q));
  reg32 #(.W(WIDTH)) u_in  (.clock(clock), .clear(clear), .load(InPortIn), .d(InPortData), .q(inport_q));
  reg32 #(.W(2*WIDTH)) u_z (.clock(clock), .clear(clear), .load(Zin),      .d(alu_result), .q(z_q));

  alu #(.W(WIDTH)) u_alu (
    .a(y_q), .b(bus), .opcode(opcode), .inc_pc(incPC), .result(alu_result)
  );

  // sources assigned lowest priority first, so the last matching strobe wins
  always_comb begin
    bus = '0;
    if (Cout)      bus = c_q;
    if (InPortOut) bus = inport_q;
    if (MDRout)    bus = mdr_q;
    if (PCout)     bus = pc_q;
    if (ZLowOut)   bus = z_q[WIDTH-1:0];
    if (ZHighOut)  bus = z_q[2*WIDTH-1:WIDTH];
    if (LOout)     bus = lo_q;
    if (HIout)     bus = hi_q;
    for (int unsigned j = 0; j < 16; j++) begin
      if (r_out[15-j]) bus = r_q[15-j];
    end
  end

  assign BusMuxOut = bus;
  assign MARout_q  = mar_q;
endmodule

// File: tb/tb_data_path.sv
// Randomized and directed check of data_path against a register-level model.
module tb_data_path;
  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] r_in, r_out;
  logic        PCin, HIin, LOin, Zin, incPC, MARin, MDRin, read, InPortIn, Cin, Yin;
  logic        HIout, LOout, ZHighOut, ZLowOut, PCout, MDRout, InPortOut, Cout;
  logic [4:0]  opcode;
  logic [31:0] Mdatain, InPortData, BusMuxOut, MARout_q;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_hi, m_lo, m_y, m_mar, m_mdr, m_c, m_inport;
  logic [63:0] m_z;

  always #5 clock = ~clock;

  data_path dut (
    .clock(clock), .clear(clear),
    .R0in(r_in[0]),   .R1in(r_in[1]),   .R2in(r_in[2]),   .R3in(r_in[3]),
    .R4in(r_in[4]),   .R5in(r_in[5]),   .R6in(r_in[6]),   .R7in(r_in[7]),
    .R8in(r_in[8]),   .R9in(r_in[9]),   .R10in(r_in[10]), .R11in(r_in[11]),
    .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .PCin(PCin), .HIin(HIin), .LOin(LOin), .Zin(Zin), .incPC(incPC),
    .MARin(MARin), .MDRin(MDRin), .read(read), .InPortIn(InPortIn),
    .Cin(Cin), .Yin(Yin), .opcode(opcode), .Mdatain(Mdatain), .InPortData(InPortData),
    .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
    .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
    .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .HIout(HIout), .LOout(LOout), .ZHighOut(ZHighOut), .ZLowOut(ZLowOut),
    .PCout(PCout), .MDRout(MDRout), .InPortOut(InPortOut), .Cout(Cout),
    .BusMuxOut(BusMuxOut), .MARout_q(MARout_q)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    r_in = '0; r_out = '0;
    {PCin, HIin, LOin, Zin, incPC, MARin, MDRin, read, InPortIn, Cin, Yin} = '0;
    {HIout, LOout, ZHighOut, ZLowOut, PCout, MDRout, InPortOut, Cout} = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    {m_pc, m_hi, m_lo, m_y, m_mar, m_mdr, m_c, m_inport} = '0;
    m_z = '0;
  endtask

  function automatic logic [31:0] model_bus();
    for (int i = 0; i < 16; i++) if (r_out[i]) return m_r[i];
    if (HIout)     return m_hi;
    if (LOout)     return m_lo;
    if (ZHighOut)  return m_z[63:32];
    if (ZLowOut)   return m_z[31:0];
    if (PCout)     return m_pc;
    if (MDRout)    return m_mdr;
    if (InPortOut) return m_inport;
    if (Cout)      return m_c;
    return '0;
  endfunction

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic inc,
                                          input logic [31:0] a, input logic [31:0] b);
    longint p, q, r;
    logic [31:0] x;
    int s;
    s = int'(b[4:0]);
    if (inc) return {32'h0, b + 32'd1};
    case (op)
      5'd0:  return {32'h0, a + b};
      5'd1:  return {32'h0, a - b};
      5'd2:  return {32'h0, a & b};
      5'd3: begin p = longint'(int'(a)) * longint'(int'(b)); return p; end
      5'd4: begin
        if (b == 0) return 64'h0;
        q = longint'(int'(a)) / longint'(int'(b));
        r = longint'(int'(a)) % longint'(int'(b));
        return {r[31:0], q[31:0]};
      end
      5'd5:  return {32'h0, a | b};
      5'd6:  return {32'h0, a >> s};
      5'd7:  return {32'h0, a << s};
      5'd8: begin x = int'(a) >>> s; return {32'h0, x}; end
      5'd9: begin
        x = a;
        for (int k = 0; k < s; k++) x = {x[0], x[31:1]};
        return {32'h0, x};
      end
      5'd10: begin
        x = a;
        for (int k = 0; k < s; k++) x = {x[30:0], x[31]};
        return {32'h0, x};
      end
      5'd11: return {32'h0, 32'd0 - b};
      5'd12: return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  // one clock step with the currently driven strobes; model updated from pre-edge bus
  task automatic cyc();
    logic [31:0] b;
    logic [63:0] zn;
    b = model_bus();
    zn = ref_alu(opcode, incPC, m_y, b);
    #1 check("bus", {32'h0, BusMuxOut}, {32'h0, b});
    @(posedge clock);
    for (int i = 0; i < 16; i++) if (r_in[i]) m_r[i] = b;
    if (PCin)     m_pc = b;
    if (HIin)     m_hi = b;
    if (LOin)     m_lo = b;
    if (Yin)      m_y = b;
    if (Cin)      m_c = b;
    if (MARin)    m_mar = b;
    if (MDRin)    m_mdr = read ? Mdatain : b;
    if (InPortIn) m_inport = InPortData;
    if (Zin)      m_z = zn;
    #1 check("mar", {32'h0, MARout_q}, {32'h0, m_mar});
    idle();
  endtask

  task automatic load_reg(input int n, input logic [31:0] v);
    Mdatain = v; read = 1'b1; MDRin = 1'b1; cyc();
    MDRout = 1'b1; r_in[n] = 1'b1; cyc();
  endtask

  task automatic peek_expect(input string tag, input logic [31:0] exp);
    #1 check(tag, {32'h0, BusMuxOut}, {32'h0, exp});
    cyc();
  endtask

  initial begin
    idle();
    opcode = '0; Mdatain = '0; InPortData = '0;
    clear = 1'b0;
    model_reset();
    #2;
    check("rst_bus", {32'h0, BusMuxOut}, 64'h0);
    check("rst_mar", {32'h0, MARout_q}, 64'h0);
    clear = 1'b1;

    load_reg(2, 32'd25);
    load_reg(6, 32'd5);
    r_out[2] = 1'b1; peek_expect("r2_25", 32'd25);
    r_out[6] = 1'b1; peek_expect("r6_5", 32'd5);

    r_out[2] = 1'b1; Yin = 1'b1; cyc();
    opcode = 5'b00011; r_out[6] = 1'b1; Zin = 1'b1; cyc();
    ZLowOut = 1'b1; LOin = 1'b1; cyc();
    ZHighOut = 1'b1; HIin = 1'b1; cyc();
    LOout = 1'b1; peek_expect("mul_lo", 32'd125);
    HIout = 1'b1; peek_expect("mul_hi", 32'd0);

    load_reg(3, 32'hFFFF_FFE7);
    r_out[3] = 1'b1; Yin = 1'b1; cyc();
    r_out[6] = 1'b1; Zin = 1'b1; cyc();
    ZLowOut = 1'b1; peek_expect("smul_lo", 32'hFFFF_FF83);
    ZHighOut = 1'b1; peek_expect("smul_hi", 32'hFFFF_FFFF);

    PCout = 1'b1; incPC = 1'b1; MARin = 1'b1; Zin = 1'b1; cyc();
    check("pc_mar", {32'h0, MARout_q}, 64'h0);
    ZLowOut = 1'b1; #1 check("pc_z1", {32'h0, BusMuxOut}, 64'd1); PCin = 1'b1; cyc();
    PCout = 1'b1; peek_expect("pc_1", 32'd1);

    opcode = 5'b00100;
    r_out[2] = 1'b1; Yin = 1'b1; cyc();
    r_out[6] = 1'b1; Zin = 1'b1; cyc();
    ZLowOut = 1'b1; peek_expect("div_q", 32'd5);
    ZHighOut = 1'b1; peek_expect("div_r", 32'd0);
    load_reg(4, 32'd7);
    load_reg(5, 32'd0);
    r_out[4] = 1'b1; Yin = 1'b1; cyc();
    r_out[5] = 1'b1; Zin = 1'b1; cyc();
    ZLowOut = 1'b1; peek_expect("div0_lo", 32'd0);
    ZHighOut = 1'b1; peek_expect("div0_hi", 32'd0);

    r_out[2] = 1'b1; r_out[6] = 1'b1; peek_expect("pri_r2_r6", 32'd25);
    r_out[6] = 1'b1; HIout = 1'b1; peek_expect("pri_r6_hi", 32'd5);
    PCout = 1'b1; Cout = 1'b1; peek_expect("pri_pc_c", 32'd1);

    r_out[2] = 1'b1; MARin = 1'b1; cyc();
    check("mar_25", {32'h0, MARout_q}, 64'd25);
    r_out[2] = 1'b1;
    clear = 1'b0;
    #1;
    check("mid_rst_bus", {32'h0, BusMuxOut}, 64'h0);
    check("mid_rst_mar", {32'h0, MARout_q}, 64'h0);
    model_reset();
    clear = 1'b1;
    idle();

    for (int t = 0; t < 400; t++) begin
      int nsrc;
      opcode     = 5'($urandom_range(0, 15));
      Mdatain    = $urandom;
      InPortData = $urandom;
      read       = 1'($urandom_range(0, 1));
      incPC      = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 16; i++) r_in[i] = ($urandom_range(0, 7) == 0);
      {PCin, HIin, LOin, Zin, MARin, MDRin, InPortIn, Cin, Yin} =
        {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
         ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
         ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0)};
      nsrc = $urandom_range(0, 2);
      for (int k = 0; k < nsrc; k++) begin
        int s;
        s = $urandom_range(0, 23);
        if (s < 16) r_out[s] = 1'b1;
        else case (s)
          16: HIout = 1'b1;
          17: LOout = 1'b1;
          18: ZHighOut = 1'b1;
          19: ZLowOut = 1'b1;
          20: PCout = 1'b1;
          21: MDRout = 1'b1;
          22: InPortOut = 1'b1;
          default: Cout = 1'b1;
        endcase
      end
      if (opcode == 5'd4 && !incPC && m_y == 32'h8000_0000 && model_bus() == 32'hFFFF_FFFF)
        Zin = 1'b0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
